// File: rtl/sdf_query_arbiter.sv
// Round-robin arbiter sharing one fixed-latency SDF query unit.
// A tag pipeline routes each result back to its requester.
module sdf_query_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 4,
  parameter int FP_W    = 32,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(LATENCY + 1),
  localparam int VW = 3 * FP_W
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         en_in,
  input  logic [NUM_REQ-1:0]           req_valid_in,
  input  logic [NUM_REQ-1:0][VW-1:0]   req_point_in,
  output logic [NUM_REQ-1:0]           req_ready_out,
  output logic [VW-1:0]                query_point_out,
  output logic                         query_valid_out,
  input  logic [FP_W-1:0]              sdf_in,
  output logic [NUM_REQ-1:0]           resp_valid_out,
  output logic [FP_W-1:0]              resp_sdf_out,
  output logic [CW-1:0]                in_flight_out,
  output logic                         idle_out
);

  function automatic logic [IW-1:0] wrap_idx(
    input logic [IW-1:0] base,
    input int            off
  );
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  logic [IW-1:0]               p_q, p_d;
  logic [VW-1:0]               point_q, point_d;
  logic [LATENCY-1:0]          tag_v_q, tag_v_d;
  logic [LATENCY-1:0][IW-1:0]  tag_idx_q, tag_idx_d;
  logic [NUM_REQ-1:0]          resp_valid_q, resp_valid_d;
  logic [FP_W-1:0]             resp_sdf_q, resp_sdf_d;
  logic [CW-1:0]               in_flight_q, in_flight_d;

  logic                        grant;
  logic [IW-1:0]               win;
  logic [NUM_REQ-1:0]          ready;
  logic                        tag_exit;
  logic [IW-1:0]               exit_idx;

  // Search starts at the pointer; reset also masks grants.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    if (en_in && !rst_in) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant && req_valid_in[wrap_idx(p_q, i)]) begin
          grant = 1'b1;
          win   = wrap_idx(p_q, i);
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    if (grant) ready[win] = 1'b1;
  end

  always_comb begin
    p_d     = p_q;
    point_d = point_q;
    if (grant) begin
      p_d     = wrap_idx(win, 1);
      point_d = req_point_in[win];
    end
  end

  assign tag_exit = tag_v_q[LATENCY-1];
  assign exit_idx = tag_idx_q[LATENCY-1];

  always_comb begin
    tag_v_d      = '0;
    tag_idx_d    = '0;
    tag_v_d[0]   = grant;
    tag_idx_d[0] = win;
    for (int i = 1; i < LATENCY; i++) begin
      tag_v_d[i]   = tag_v_q[i-1];
      tag_idx_d[i] = tag_idx_q[i-1];
    end
  end

  always_comb begin
    resp_valid_d = '0;
    resp_sdf_d   = resp_sdf_q;
    if (tag_exit) begin
      resp_valid_d[exit_idx] = 1'b1;
      resp_sdf_d             = sdf_in;
    end
  end

  // A grant and an exit in the same cycle cancel out.
  always_comb begin
    in_flight_d = in_flight_q;
    if (grant && !tag_exit)
      in_flight_d = in_flight_q + CW'(1);
    else if (!grant && tag_exit)
      in_flight_d = in_flight_q - CW'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      p_q          <= '0;
      point_q      <= '0;
      tag_v_q      <= '0;
      tag_idx_q    <= '0;
      resp_valid_q <= '0;
      resp_sdf_q   <= '0;
      in_flight_q  <= '0;
    end else begin
      p_q          <= p_d;
      point_q      <= point_d;
      tag_v_q      <= tag_v_d;
      tag_idx_q    <= tag_idx_d;
      resp_valid_q <= resp_valid_d;
      resp_sdf_q   <= resp_sdf_d;
      in_flight_q  <= in_flight_d;
    end
  end

  assign req_ready_out   = ready;
  assign query_valid_out = grant;
  assign query_point_out = point_d;
  assign resp_valid_out  = resp_valid_q;
  assign resp_sdf_out    = resp_sdf_q;
  assign in_flight_out   = in_flight_q;
  assign idle_out        = (in_flight_q == '0) && !grant;

endmodule

// File: tb/tb_sdf_query_arbiter.sv
// Bench for sdf_query_arbiter: grant model, scoreboard of
// outstanding queries and a LATENCY-deep SDF unit model.
module tb_sdf_query_arbiter;

  localparam int NR  = 4;
  localparam int LAT = 4;
  localparam int FW  = 32;
  localparam int VW  = 3 * FW;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic                 en_in;
  logic [NR-1:0]        req_valid_in;
  logic [NR-1:0][VW-1:0] req_point_in;
  logic [NR-1:0]        req_ready_out;
  logic [VW-1:0]        query_point_out;
  logic                 query_valid_out;
  logic [FW-1:0]        sdf_in;
  logic [NR-1:0]        resp_valid_out;
  logic [FW-1:0]        resp_sdf_out;
  logic [2:0]           in_flight_out;
  logic                 idle_out;

  sdf_query_arbiter #(.NUM_REQ(NR), .LATENCY(LAT), .FP_W(FW)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .en_in           (en_in),
    .req_valid_in    (req_valid_in),
    .req_point_in    (req_point_in),
    .req_ready_out   (req_ready_out),
    .query_point_out (query_point_out),
    .query_valid_out (query_valid_out),
    .sdf_in          (sdf_in),
    .resp_valid_out  (resp_valid_out),
    .resp_sdf_out    (resp_sdf_out),
    .in_flight_out   (in_flight_out),
    .idle_out        (idle_out)
  );

  always #5 clk_in = ~clk_in;

  int n_vec  = 0;
  int n_fail = 0;

  // SDF unit model: distance = x, returned LAT cycles later.
  logic [FW-1:0] sdf_pipe [0:LAT];
  initial for (int i = 0; i <= LAT; i++) sdf_pipe[i] = '0;
  always @(negedge clk_in) begin
    sdf_pipe[0] <= query_point_out[FW-1:0];
    for (int i = 1; i <= LAT; i++) sdf_pipe[i] <= sdf_pipe[i-1];
  end
  assign sdf_in = sdf_pipe[LAT];

  typedef struct {
    int            idx;
    logic [FW-1:0] val;
  } exp_t;

  exp_t          sb[$];
  exp_t          e;
  int            exp_p = 0;
  int            mw;
  logic [NR-1:0] mexp;
  logic [VW-1:0] exp_last = '0;
  logic [FW-1:0] exp_sdf  = '0;

  // Per-cycle monitor: grant model pushes, responses pop.
  always @(negedge clk_in) begin
    if (rst_in) begin
      n_vec++;
      if (resp_valid_out !== '0 || req_ready_out !== '0 ||
          query_valid_out !== 1'b0 || in_flight_out !== '0 ||
          resp_sdf_out !== '0 || query_point_out !== '0) begin
        n_fail++;
        $display("FAIL mon_reset: rv=%b rdy=%b qv=%b if=%0d sdf=%0d required all 0",
                 resp_valid_out, req_ready_out, query_valid_out,
                 in_flight_out, resp_sdf_out);
      end
      sb.delete();
      exp_p    = 0;
      exp_last = '0;
      exp_sdf  = '0;
    end else begin
      if (resp_valid_out !== '0) begin
        n_vec++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL mon_unexpected_resp: got %b required none",
                   resp_valid_out);
        end else begin
          e = sb.pop_front();
          exp_sdf = e.val;
          mexp = NR'(1 << e.idx);
          n_vec++;
          if (resp_valid_out !== mexp || resp_sdf_out !== e.val) begin
            n_fail++;
            $display("FAIL mon_resp: got %b/%0d required %b/%0d",
                     resp_valid_out, resp_sdf_out, mexp, e.val);
          end
        end
      end else begin
        n_vec++;
        if (resp_sdf_out !== exp_sdf) begin
          n_fail++;
          $display("FAIL mon_sdf_hold: got %0d required %0d",
                   resp_sdf_out, exp_sdf);
        end
      end
      n_vec++;
      if (in_flight_out !== 3'(sb.size())) begin
        n_fail++;
        $display("FAIL mon_in_flight: got %0d required %0d",
                 in_flight_out, sb.size());
      end
      mw = -1;
      if (en_in)
        for (int i = 0; i < NR; i++)
          if (mw < 0 && req_valid_in[(exp_p + i) % NR]) mw = (exp_p + i) % NR;
      mexp = (mw >= 0) ? NR'(1 << mw) : '0;
      n_vec++;
      if (req_ready_out !== mexp || query_valid_out !== (mw >= 0)) begin
        n_fail++;
        $display("FAIL mon_grant: got %b/%b required %b/%b",
                 req_ready_out, query_valid_out, mexp, (mw >= 0));
      end
      n_vec++;
      if (idle_out !== (sb.size() == 0 && mw < 0)) begin
        n_fail++;
        $display("FAIL mon_idle: got %b required %b",
                 idle_out, (sb.size() == 0 && mw < 0));
      end
      if (mw >= 0) exp_last = req_point_in[mw];
      n_vec++;
      if (query_point_out !== exp_last) begin
        n_fail++;
        $display("FAIL mon_point: got %h required %h",
                 query_point_out, exp_last);
      end
      if (mw >= 0) begin
        e.idx = mw;
        e.val = req_point_in[mw][FW-1:0];
        sb.push_back(e);
        exp_p = (mw + 1) % NR;
      end
    end
  end

  task automatic test_reset();
    req_valid_in = 4'b1111;
    en_in = 1'b1;
    @(negedge clk_in);
    n_vec++;
    if (req_ready_out !== 4'b0000 || query_valid_out !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_grant: got %b/%b required 0000/0",
               req_ready_out, query_valid_out);
    end
    n_vec++;
    if (resp_valid_out !== '0 || resp_sdf_out !== '0 ||
        in_flight_out !== '0 || query_point_out !== '0 || idle_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: rv=%b sdf=%0d if=%0d idle=%b required 0/0/0/1",
               resp_valid_out, resp_sdf_out, in_flight_out, idle_out);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    req_valid_in = 4'b0000;
  endtask

  task automatic test_single();
    @(posedge clk_in); #1;
    req_point_in[1] = {32'd9, 32'd8, 32'd5};
    req_valid_in = 4'b0010;
    @(negedge clk_in);
    n_vec++;
    if (req_ready_out !== 4'b0010) begin
      n_fail++;
      $display("FAIL single_ready: got %b required 0010", req_ready_out);
    end
    @(posedge clk_in); #1;
    req_valid_in = 4'b0000;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_in);
      n_vec++;
      if (resp_valid_out !== ((i == 5) ? 4'b0010 : 4'b0000)) begin
        n_fail++;
        $display("FAIL single_resp_valid c%0d: got %b", i, resp_valid_out);
      end
      n_vec++;
      if (in_flight_out !== ((i < 5) ? 3'd1 : 3'd0)) begin
        n_fail++;
        $display("FAIL single_in_flight c%0d: got %0d required %0d",
                 i, in_flight_out, (i < 5) ? 1 : 0);
      end
    end
    n_vec++;
    if (resp_sdf_out !== 32'd5) begin
      n_fail++;
      $display("FAIL single_sdf: got %0d required 5", resp_sdf_out);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] er, ev;
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    req_valid_in = 4'b1111;
    for (int t = 0; t <= 14; t++) begin
      @(negedge clk_in);
      er = (t < 8) ? 4'(1 << (t % 4)) : 4'b0000;
      ev = (t >= 5 && t < 13) ? 4'(1 << ((t - 5) % 4)) : 4'b0000;
      n_vec++;
      if (req_ready_out !== er || resp_valid_out !== ev) begin
        n_fail++;
        $display("FAIL rr t%0d: rdy=%b rv=%b required %b/%b",
                 t, req_ready_out, resp_valid_out, er, ev);
      end
      if (t >= 5 && t <= 7) begin
        n_vec++;
        if (in_flight_out !== 3'd4) begin
          n_fail++;
          $display("FAIL rr_in_flight_full t%0d: got %0d required 4",
                   t, in_flight_out);
        end
      end
      if (t == 7) begin
        @(posedge clk_in); #1;
        req_valid_in = 4'b0000;
      end
    end
  endtask

  task automatic test_priority();
    logic [3:0] er;
    @(posedge clk_in); #1;
    req_valid_in = 4'b0010;
    @(negedge clk_in);
    n_vec++;
    if (req_ready_out !== 4'b0010) begin
      n_fail++;
      $display("FAIL prio_setup: got %b required 0010", req_ready_out);
    end
    @(posedge clk_in); #1;
    req_valid_in = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      er = (i % 2 == 0) ? 4'b1000 : 4'b0010;
      n_vec++;
      if (req_ready_out !== er) begin
        n_fail++;
        $display("FAIL prio_grant %0d: got %b required %b",
                 i, req_ready_out, er);
      end
      @(posedge clk_in); #1;
      if (i == 3) req_valid_in = 4'b0000;
    end
    for (int i = 0; i < 8; i++) @(negedge clk_in);
  endtask

  task automatic test_enable_drain();
    int exp_if [5] = '{3, 3, 2, 1, 0};
    @(posedge clk_in); #1;
    req_valid_in = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      @(posedge clk_in);
    end
    #1;
    en_in = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk_in);
      n_vec++;
      if (in_flight_out !== 3'(exp_if[j-1]) || req_ready_out !== 4'b0000) begin
        n_fail++;
        $display("FAIL drain_in_flight c%0d: got %0d/%b required %0d/0000",
                 j, in_flight_out, req_ready_out, exp_if[j-1]);
      end
      n_vec++;
      if ((resp_valid_out != 4'b0000) !== (j >= 3)) begin
        n_fail++;
        $display("FAIL drain_resp c%0d: got %b", j, resp_valid_out);
      end
      n_vec++;
      if (idle_out !== (j == 5)) begin
        n_fail++;
        $display("FAIL drain_idle c%0d: got %b required %b",
                 j, idle_out, (j == 5));
      end
    end
    @(posedge clk_in); #1;
    req_valid_in = 4'b0000;
    en_in = 1'b1;
  endtask

  task automatic test_reset_flush();
    @(posedge clk_in); #1;
    req_valid_in = 4'b0011;
    @(negedge clk_in);
    @(posedge clk_in);
    @(negedge clk_in);
    @(posedge clk_in); #1;
    req_valid_in = 4'b0000;
    @(negedge clk_in);
    n_vec++;
    if (in_flight_out !== 3'd2) begin
      n_fail++;
      $display("FAIL flush_pre: got %0d required 2", in_flight_out);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b1;
    req_valid_in = 4'b0011;
    @(negedge clk_in);
    n_vec++;
    if (in_flight_out !== 3'd0 || req_ready_out !== 4'b0000 ||
        resp_sdf_out !== '0 || query_point_out !== '0) begin
      n_fail++;
      $display("FAIL flush_clear: if=%0d rdy=%b sdf=%0d required 0/0000/0",
               in_flight_out, req_ready_out, resp_sdf_out);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    req_valid_in = 4'b0000;
    for (int i = 1; i <= LAT + 2; i++) begin
      @(negedge clk_in);
      n_vec++;
      if (resp_valid_out !== 4'b0000) begin
        n_fail++;
        $display("FAIL flush_no_resp c%0d: got %b required 0000",
                 i, resp_valid_out);
      end
    end
  endtask

  initial begin
    rst_in = 1'b1;
    en_in = 1'b0;
    req_valid_in = '0;
    for (int k = 0; k < NR; k++)
      req_point_in[k] = {32'(k + 7), 32'(k + 3), 32'(100 + k)};
    test_reset();
    test_single();
    test_round_robin();
    test_priority();
    test_enable_drain();
    test_reset_flush();
    @(negedge clk_in);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
